// File: rtl/iir_sine_osc_param.sv
// Two-pole IIR resonator sine generator with programmable coefficient and
// initial state, sample-rate strobe, pause/clear, saturation, zero-crossing and period measurement.
module iir_sine_osc_param #(
    parameter int DATA_W    = 16,
    parameter int COEF_W    = 18,
    parameter int COEF_FRAC = 16,
    parameter int PER_W     = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic signed [COEF_W-1:0] cfg_coef,
    input  logic signed [DATA_W-1:0] cfg_y1,
    input  logic signed [DATA_W-1:0] cfg_y2,
    input  logic                     run,
    input  logic                     clear,
    input  logic                     sample_en,
    output logic signed [DATA_W-1:0] q,
    output logic                     q_valid,
    output logic                     zc,
    output logic [PER_W-1:0]         period,
    output logic                     sat_flag,
    output logic                     busy
);
    localparam int PW = DATA_W + COEF_W;
    localparam logic signed [PW-1:0] HALF = PW'(1) << (COEF_FRAC - 1);
    localparam logic signed [PW-1:0] MAXV = {{(COEF_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [PW-1:0] MINV = {{(COEF_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_PAUSE = 2'd2} state_t;

    state_t                    r_state, w_next;
    logic signed [COEF_W-1:0]  r_coef;
    logic signed [DATA_W-1:0]  r_y1, r_y2, r_q;
    logic [PER_W-1:0]          r_cnt, r_period;
    logic                      r_q_valid, r_zc, r_sat;

    logic                      w_accept, w_step, w_zc, w_clip;
    logic signed [PW-1:0]      w_coef_ext, w_y1_ext, w_y2_ext, w_prod, w_s;
    logic signed [DATA_W-1:0]  w_ynew;
    logic [PER_W-1:0]          w_cnt_inc;

    function automatic logic signed [PW-1:0] round_q(input logic signed [PW-1:0] p);
        return (p + HALF) >>> COEF_FRAC;
    endfunction

    function automatic logic clipped(input logic signed [PW-1:0] s);
        return (s > MAXV) || (s < MINV);
    endfunction

    function automatic logic signed [DATA_W-1:0] saturate(input logic signed [PW-1:0] s);
        if (s > MAXV)
            return MAXV[DATA_W-1:0];
        else if (s < MINV)
            return MINV[DATA_W-1:0];
        else
            return s[DATA_W-1:0];
    endfunction

    // A config accept takes precedence over a coincident sample strobe.
    assign w_accept   = cfg_valid && !clear;
    assign w_step     = (r_state == S_RUN) && sample_en && !w_accept && !clear;

    assign w_coef_ext = {{DATA_W{r_coef[COEF_W-1]}}, r_coef};
    assign w_y1_ext   = {{COEF_W{r_y1[DATA_W-1]}}, r_y1};
    assign w_y2_ext   = {{COEF_W{r_y2[DATA_W-1]}}, r_y2};
    assign w_prod     = w_coef_ext * w_y1_ext;
    assign w_s        = round_q(w_prod) - w_y2_ext;
    assign w_ynew     = saturate(w_s);
    assign w_clip     = clipped(w_s);
    assign w_zc       = w_step && (r_y1 < 0) && (w_ynew >= 0);
    assign w_cnt_inc  = (&r_cnt) ? r_cnt : r_cnt + PER_W'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (clear)
            w_next = S_IDLE;
        else if (w_accept)
            w_next = run ? S_RUN : S_PAUSE;
        else if (r_state == S_RUN && !run)
            w_next = S_PAUSE;
        else if (r_state == S_PAUSE && run)
            w_next = S_RUN;
    end

    always_comb begin
        busy      = (r_state != S_IDLE);
        cfg_ready = !clear;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_coef    <= '0;
            r_y1      <= '0;
            r_y2      <= '0;
            r_q       <= '0;
            r_cnt     <= '0;
            r_period  <= '0;
            r_q_valid <= 1'b0;
            r_zc      <= 1'b0;
            r_sat     <= 1'b0;
        end else if (clear) begin
            r_coef    <= '0;
            r_y1      <= '0;
            r_y2      <= '0;
            r_q       <= '0;
            r_cnt     <= '0;
            r_period  <= '0;
            r_q_valid <= 1'b0;
            r_zc      <= 1'b0;
            r_sat     <= 1'b0;
        end else begin
            r_q_valid <= w_step;
            r_zc      <= w_zc;
            if (w_accept) begin
                r_coef <= cfg_coef;
                r_y1   <= cfg_y1;
                r_y2   <= cfg_y2;
                r_q    <= cfg_y1;
                r_cnt  <= '0;
                r_sat  <= 1'b0;
            end else if (w_step) begin
                r_y2 <= r_y1;
                r_y1 <= w_ynew;
                r_q  <= w_ynew;
                if (w_clip)
                    r_sat <= 1'b1;
                // Period counts samples since the previous crossing, this one included.
                if (w_zc) begin
                    r_period <= w_cnt_inc;
                    r_cnt    <= '0;
                end else begin
                    r_cnt <= w_cnt_inc;
                end
            end
        end
    end

    assign q        = r_q;
    assign q_valid  = r_q_valid;
    assign zc       = r_zc;
    assign period   = r_period;
    assign sat_flag = r_sat;
endmodule

// File: tb/tb_iir_sine_osc_param.sv
// Randomised and directed bench for iir_sine_osc_param against a behavioural
// model of the resonator built from plain integer arithmetic.
module tb_iir_sine_osc_param;
    localparam int DATA_W    = 16;
    localparam int COEF_W    = 18;
    localparam int COEF_FRAC = 16;
    localparam int PER_W     = 16;
    localparam longint YMAX  = (longint'(1) << (DATA_W - 1)) - 1;
    localparam longint YMIN  = -(longint'(1) << (DATA_W - 1));
    localparam longint PMAX  = (longint'(1) << PER_W) - 1;

    logic clk = 1'b0, reset_n = 1'b0;
    logic cfg_valid = 1'b0, run = 1'b0, clear = 1'b0, sample_en = 1'b0;
    logic signed [COEF_W-1:0] cfg_coef = '0;
    logic signed [DATA_W-1:0] cfg_y1 = '0, cfg_y2 = '0;
    logic cfg_ready, q_valid, zc, sat_flag, busy;
    logic signed [DATA_W-1:0] q;
    logic [PER_W-1:0] period;

    int n_asrt = 0, n_fail = 0;

    iir_sine_osc_param #(.DATA_W(DATA_W), .COEF_W(COEF_W), .COEF_FRAC(COEF_FRAC), .PER_W(PER_W)) dut (
        .clk(clk), .reset_n(reset_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_coef(cfg_coef), .cfg_y1(cfg_y1), .cfg_y2(cfg_y2), .run(run), .clear(clear),
        .sample_en(sample_en), .q(q), .q_valid(q_valid), .zc(zc), .period(period),
        .sat_flag(sat_flag), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_asrt++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: mode 0 = no config, 1 = generating, 2 = paused.
    longint m_coef, m_y1, m_y2, m_q, m_cnt, m_period;
    bit     m_qv, m_zc, m_sat, m_per_known;
    int     m_mode, m_zcs;

    function automatic longint next_sample(input longint c, input longint y1, input longint y2,
                                           output bit clip);
        longint s;
        s = ((c * y1 + (longint'(1) << (COEF_FRAC - 1))) >>> COEF_FRAC) - y2;
        clip = (s > YMAX) || (s < YMIN);
        if (s > YMAX) s = YMAX;
        if (s < YMIN) s = YMIN;
        return s;
    endfunction

    task automatic model_reset();
        m_coef = 0; m_y1 = 0; m_y2 = 0; m_q = 0; m_cnt = 0; m_period = 0;
        m_qv = 0; m_zc = 0; m_sat = 0; m_mode = 0; m_zcs = 0; m_per_known = 1;
    endtask

    task automatic model_step();
        longint yn;
        bit clip;
        m_qv = 0;
        m_zc = 0;
        if (clear) begin
            model_reset();
            return;
        end
        if (cfg_valid) begin
            m_coef = cfg_coef; m_y1 = cfg_y1; m_y2 = cfg_y2; m_q = cfg_y1;
            m_cnt = 0; m_sat = 0; m_zcs = 0; m_per_known = 0;
            m_mode = run ? 1 : 2;
            return;
        end
        if (m_mode == 1 && sample_en) begin
            yn = next_sample(m_coef, m_y1, m_y2, clip);
            if (clip) m_sat = 1;
            m_zc = (m_y1 < 0) && (yn >= 0);
            m_y2 = m_y1; m_y1 = yn; m_q = yn; m_qv = 1;
            if (m_zc) begin
                m_period = (m_cnt + 1 > PMAX) ? PMAX : m_cnt + 1;
                m_cnt = 0;
                m_zcs++;
                if (m_zcs >= 2) m_per_known = 1;
            end else begin
                m_cnt = (m_cnt + 1 > PMAX) ? PMAX : m_cnt + 1;
            end
        end
        if (m_mode == 1 && !run) m_mode = 2;
        else if (m_mode == 2 && run) m_mode = 1;
    endtask

    task automatic compare_all();
        chk("q", q, m_q);
        chk("q_valid", q_valid, m_qv);
        chk("zc", zc, m_zc);
        chk("busy", busy, (m_mode != 0));
        chk("sat_flag", sat_flag, m_sat);
        chk("cfg_ready", cfg_ready, !clear);
        if (m_per_known) chk("period", period, m_period);
    endtask

    bit     tone_on = 0;
    int     tone_idx = 0;
    longint peak = 0;
    longint golden[64];

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
        if (tone_on && q_valid) begin
            if (tone_idx == 0) chk("first_q", q, 11314);
            if (tone_idx < 64) chk("tone_seq", q, golden[tone_idx]);
            if (q > peak) peak = q;
            tone_idx++;
        end
    endtask

    task automatic load(input longint c, input longint y1, input longint y2, input bit rn);
        cfg_coef  = COEF_W'(c);
        cfg_y1    = DATA_W'(y1);
        cfg_y2    = DATA_W'(y2);
        run       = rn;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
    endtask

    initial begin
        longint gy1, gy2;
        bit gclip;
        int c;

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        reset_n = 1'b1;
        repeat (3) tick();

        // Uninterrupted reference sequence for the pi/8 tone.
        gy1 = 6123; gy2 = 0;
        for (int i = 0; i < 64; i++) begin
            golden[i] = next_sample(121095, gy1, gy2, gclip);
            gy2 = gy1; gy1 = golden[i];
        end

        // Tone with strobe every 4th clock, paused after 5 samples.
        load(121095, 6123, 0, 1'b1);
        tone_on = 1; tone_idx = 0; peak = 0;
        c = 0;
        while (tone_idx < 5 && c < 200) begin
            sample_en = (c % 4 == 3); tick(); c++;
        end
        run = 1'b0;
        for (int k = 0; k < 24; k++) begin
            sample_en = (c % 4 == 3); tick(); c++;
        end
        chk("pause_hold", q, golden[4]);
        run = 1'b1;
        while (tone_idx < 40 && c < 1000) begin
            sample_en = (c % 4 == 3); tick(); c++;
        end
        sample_en = 1'b0;
        tone_on = 0;
        chk("tone_count", tone_idx, 40);
        chk("tone_peak", (peak >= 15998 && peak <= 16002), 1);
        chk("tone_period", (period >= 15 && period <= 17), 1);
        chk("tone_nosat", sat_flag, 0);

        // Asynchronous reset between clock edges.
        #3;
        reset_n = 1'b0;
        model_reset();
        #1;
        compare_all();
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        tick();

        // Saturation is sticky until the next config.
        load(131071, 32767, -32768, 1'b1);
        sample_en = 1'b1; tick(); sample_en = 1'b0; tick();
        chk("sat_q", q, 32767);
        chk("sat_set", sat_flag, 1);
        for (int k = 0; k < 12; k++) begin
            sample_en = (k % 3 == 0); tick();
        end
        sample_en = 1'b0;
        chk("sat_sticky", sat_flag, 1);
        load(121095, 6123, 0, 1'b1);
        chk("sat_cleared", sat_flag, 0);

        // Config accept collides with a sample strobe.
        for (int k = 0; k < 6; k++) begin
            sample_en = (k % 2 == 0); tick();
        end
        sample_en = 1'b1;
        load(100000, -1234, 0, 1'b1);
        sample_en = 1'b0;
        tick();
        chk("coll_qv", q_valid, 0);
        chk("coll_q", q, -1234);

        // Clear during RUN, then strobes without a config.
        for (int k = 0; k < 4; k++) begin
            sample_en = 1'b1; tick();
        end
        clear = 1'b1; tick(); clear = 1'b0;
        chk("clr_q", q, 0);
        chk("clr_busy", busy, 0);
        for (int k = 0; k < 8; k++) begin
            sample_en = 1'b1; tick();
            chk("clr_noqv", q_valid, 0);
        end
        sample_en = 1'b0;

        // Random traffic: tones, arbitrary states, pauses, clears, collisions.
        for (int k = 0; k < 4000; k++) begin
            cfg_valid = ($urandom_range(0, 149) == 0);
            if (cfg_valid) begin
                if ($urandom_range(0, 1) == 1) begin
                    real w, a;
                    w = 2.0 * 3.14159265358979 / real'($urandom_range(8, 40));
                    a = real'($urandom_range(1000, 30000));
                    cfg_coef = COEF_W'(longint'($cos(w) * 131072.0));
                    cfg_y1   = DATA_W'(longint'(a * $sin(w)));
                    cfg_y2   = '0;
                end else begin
                    cfg_coef = COEF_W'(int'($urandom_range(0, 262143)) - 131072);
                    cfg_y1   = DATA_W'(int'($urandom_range(0, 65535)) - 32768);
                    cfg_y2   = DATA_W'(int'($urandom_range(0, 65535)) - 32768);
                end
            end
            sample_en = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 29) == 0) run = ~run;
            clear = ($urandom_range(0, 399) == 0);
            tick();
        end
        cfg_valid = 1'b0; clear = 1'b0; sample_en = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
